// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port synchronous video RAM between the
// display fetch path and the CPU bus.
//
// - Video fetches have absolute priority and a fixed one-cycle latency.
// - CPU accesses use a req/ack handshake and fill the idle memory cycles.
// - A CPU access takes two cycles: a grant cycle and an ack cycle.
//   The port is free for video during the ack cycle.
//
// Optional feature, enabled by defining VRAM_WAIT_STATS_EN:
// - Adds parameter WAIT_W and output cpu_wait_max.
// - cpu_wait_max is the longest run of consecutive cycles in which a CPU
//   request was stalled by video, saturating at all-ones.
module vram_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
`ifdef VRAM_WAIT_STATS_EN
  ,
  parameter int WAIT_W = 8
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef VRAM_WAIT_STATS_EN
  ,
  output logic [WAIT_W-1:0] cpu_wait_max
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state;
  state_t            stateNext;
  logic              vidGrant;
  logic              cpuGrant;
  logic [ADDR_W-1:0] lastAddr;
  logic [DATA_W-1:0] vidDataHold;
  logic [DATA_W-1:0] cpuRdataHold;

  // Per-cycle grant and RAM port drive: video always wins, and the CPU only
  // gets cycles in IDLE. Grants are gated by reset_n so the RAM port shows
  // its reset values (and never writes) while reset is held.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/else can leave it unassigned and infer a latch.
    vidGrant  = reset_n & vid_req;
    cpuGrant  = reset_n & ~vid_req & cpu_req & (state == IDLE);
    mem_addr  = lastAddr;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (vidGrant) begin
      mem_addr = vid_addr;
    end else if (cpuGrant) begin
      mem_addr  = cpu_addr;
      mem_we    = cpu_we;
      mem_wdata = cpu_wdata;
    end
  end

  // CPU FSM next state: a grant moves to GRANT, and GRANT always lasts one cycle.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (cpuGrant) stateNext = GRANT;
      GRANT:   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // State register. Reset mid-GRANT drops the pending ack.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples pre-edge values regardless of block ordering.
    if (!reset_n) state <= IDLE;
    else          state <= stateNext;
  end

  // Pipeline flag for video. The RAM port address is held while the port is unowned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vid_valid <= 1'b0;
      lastAddr  <= '0;
    end else begin
      vid_valid <= vidGrant;
      lastAddr  <= mem_addr;
    end
  end

  // Capture the returned bytes, so each data output holds its value after its strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vidDataHold  <= '0;
      cpuRdataHold <= '0;
    end else begin
      if (vid_valid) vidDataHold  <= mem_rdata;
      if (cpu_ack)   cpuRdataHold <= mem_rdata;
    end
  end

  // The synchronous RAM returns data one cycle after the address. Each
  // strobe therefore passes mem_rdata straight through in its cycle.
  assign cpu_ack   = (state == GRANT);
  assign cpu_rdata = cpu_ack ? mem_rdata : cpuRdataHold;
  assign vid_data  = vid_valid ? mem_rdata : vidDataHold;

`ifdef VRAM_WAIT_STATS_EN
  logic [WAIT_W-1:0] waitRun;
  logic [WAIT_W-1:0] waitRunNext;
  logic [WAIT_W-1:0] waitMax;
  logic              cpuStall;

  // Length of the current stall run: grows while video blocks a pending CPU
  // request in IDLE. It clears on a CPU grant or when the request goes away.
  always_comb begin
    cpuStall    = cpu_req & vid_req & (state == IDLE);
    waitRunNext = waitRun;
    if (cpuStall) begin
      if (waitRun != '1) waitRunNext = waitRun + 1'b1;
    end else if (cpuGrant || !cpu_req) begin
      waitRunNext = '0;
    end
  end

  // Track the running stall length and its maximum since reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      waitRun <= '0;
      waitMax <= '0;
    end else begin
      waitRun <= waitRunNext;
      if (waitRunNext > waitMax) waitMax <= waitRunNext;
    end
  end

  assign cpu_wait_max = waitMax;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: self-checking bench for vram_arbiter.
//
// - A behavioural RAM model sits behind the arbiter.
// - A cycle-level reference model tracks the expected RAM contents (refMem),
//   the grant rules and the response timing.
// - Wait-statistics checks are compiled in when VRAM_WAIT_STATS_EN is defined.
module tb_vram_arbiter;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;
`ifdef VRAM_WAIT_STATS_EN
  localparam int WAIT_W = 8;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              vid_req = 1'b0;
  logic [ADDR_W-1:0] vid_addr = '0;
  logic [DATA_W-1:0] vid_data;
  logic              vid_valid;
  logic              cpu_req = 1'b0;
  logic              cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
`ifdef VRAM_WAIT_STATS_EN
  logic [WAIT_W-1:0] cpu_wait_max;
`endif

  always #5 clk = ~clk;

  vram_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
`ifdef VRAM_WAIT_STATS_EN
    , .WAIT_W(WAIT_W)
`endif
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .vid_req   (vid_req),
    .vid_addr  (vid_addr),
    .vid_data  (vid_data),
    .vid_valid (vid_valid),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef VRAM_WAIT_STATS_EN
    , .cpu_wait_max(cpu_wait_max)
`endif
  );

  // Synchronous 2Kx8 RAM: read data appears one cycle after the address.
  logic [7:0] ram [0:2047];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Counters and reference-model state.
  int nCmp = 0;
  int nFail = 0;
  int cyc = 0;
  int lastGrant = -100;      // cycle index of the most recent CPU grant
  int waitRun = 0;
  int waitMax = 0;
  int eWaitMax = 0;
  logic [7:0]  refMem [0:2047];
  logic [10:0] expLastAddr = '0;
  logic        eVidValid = 0, eCpuAck = 0, eCpuRead = 0;
  logic [7:0]  eVidData = '0, eCpuRdata = '0;

  // Outputs observed mid-cycle by the most recent step, for the scenario checks.
  logic [10:0] obsAddr;
  logic        obsWe, obsVidValid, obsAck;
  logic [7:0]  obsVidData, obsRdata;
  int          obsWaitMax;

  // Drive one cycle and score it against the reference model.
  // The task is entered and left 1 ns after a rising edge.
  task automatic run_cycle(input logic vr, input logic [10:0] va, input logic cr,
                           input logic cwe, input logic [10:0] ca, input logic [7:0] cwd);
    logic [10:0] xAddr;
    logic        xWe, cpuG, ackCyc, nVidValid, nCpuAck, nCpuRead;
    logic [7:0]  nVidData, nCpuRdata;
    vid_req = vr; vid_addr = va; cpu_req = cr; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cwd;
    ackCyc = (cyc == lastGrant + 1);
    nVidValid = 0; nVidData = '0; nCpuAck = 0; nCpuRead = 0; nCpuRdata = '0;
    xAddr = expLastAddr; xWe = 0; cpuG = 0;
    if (vr) begin
      xAddr = va; nVidValid = 1; nVidData = refMem[va];
    end else if (cr && !ackCyc) begin
      cpuG = 1; xAddr = ca; xWe = cwe; lastGrant = cyc;
      nCpuAck = 1; nCpuRead = !cwe; nCpuRdata = refMem[ca];
    end
    if (cr && vr && !ackCyc) begin
      if (waitRun < 255) waitRun++;
      if (waitRun > waitMax) waitMax = waitRun;
    end else if (cpuG || !cr) begin
      waitRun = 0;
    end
    @(negedge clk);
    obsAddr = mem_addr; obsWe = mem_we; obsVidValid = vid_valid; obsVidData = vid_data;
    obsAck = cpu_ack; obsRdata = cpu_rdata;
    nCmp++;
    if (mem_addr !== xAddr) begin
      nFail++; $display("FAIL mem_addr cyc=%0d: got %h expected %h", cyc, mem_addr, xAddr);
    end
    nCmp++;
    if (mem_we !== xWe) begin
      nFail++; $display("FAIL mem_we cyc=%0d: got %b expected %b", cyc, mem_we, xWe);
    end
    if (cpuG && cwe) begin
      nCmp++;
      if (mem_wdata !== cwd) begin
        nFail++; $display("FAIL mem_wdata cyc=%0d: got %h expected %h", cyc, mem_wdata, cwd);
      end
      refMem[ca] = cwd;
    end
    nCmp++;
    if (vid_valid !== eVidValid) begin
      nFail++; $display("FAIL vid_valid cyc=%0d: got %b expected %b", cyc, vid_valid, eVidValid);
    end
    if (eVidValid) begin
      nCmp++;
      if (vid_data !== eVidData) begin
        nFail++; $display("FAIL vid_data cyc=%0d: got %h expected %h", cyc, vid_data, eVidData);
      end
    end
    nCmp++;
    if (cpu_ack !== eCpuAck) begin
      nFail++; $display("FAIL cpu_ack cyc=%0d: got %b expected %b", cyc, cpu_ack, eCpuAck);
    end
    if (eCpuAck && eCpuRead) begin
      nCmp++;
      if (cpu_rdata !== eCpuRdata) begin
        nFail++; $display("FAIL cpu_rdata cyc=%0d: got %h expected %h", cyc, cpu_rdata, eCpuRdata);
      end
    end
`ifdef VRAM_WAIT_STATS_EN
    obsWaitMax = int'(cpu_wait_max);
    nCmp++;
    if (int'(cpu_wait_max) != eWaitMax) begin
      nFail++; $display("FAIL cpu_wait_max cyc=%0d: got %0d expected %0d", cyc, cpu_wait_max, eWaitMax);
    end
`else
    obsWaitMax = 0;
`endif
    expLastAddr = xAddr;
    @(posedge clk); #1;
    cyc++;
    eVidValid = nVidValid; eVidData = nVidData;
    eCpuAck = nCpuAck; eCpuRead = nCpuRead; eCpuRdata = nCpuRdata;
    eWaitMax = waitMax;
  endtask

  // Hold reset for n cycles, with every request active, and check the reset values.
  task automatic reset_dut(input int n);
    reset_n = 0;
    for (int i = 0; i < n; i++) begin
      vid_req = 1; vid_addr = 11'($urandom); cpu_req = 1; cpu_we = 1;
      cpu_addr = 11'($urandom); cpu_wdata = 8'($urandom);
      @(negedge clk);
      obsAck = cpu_ack;
      nCmp++;
      if ({vid_valid, cpu_ack, mem_we} !== 3'b000) begin
        nFail++; $display("FAIL reset_strobes: got vv=%b ack=%b we=%b expected 0", vid_valid, cpu_ack, mem_we);
      end
      nCmp++;
      if ({vid_data, cpu_rdata, mem_wdata, mem_addr} !== 35'd0) begin
        nFail++; $display("FAIL reset_data: got vd=%h rd=%h wd=%h addr=%h expected 0",
                          vid_data, cpu_rdata, mem_wdata, mem_addr);
      end
`ifdef VRAM_WAIT_STATS_EN
      nCmp++;
      if (cpu_wait_max !== '0) begin
        nFail++; $display("FAIL reset_wait_max: got %0d expected 0", cpu_wait_max);
      end
`endif
      @(posedge clk); #1;
      cyc++;
    end
    vid_req = 0; cpu_req = 0; cpu_we = 0;
    eVidValid = 0; eCpuAck = 0; eCpuRead = 0; lastGrant = -100; expLastAddr = '0;
    waitRun = 0; waitMax = 0; eWaitMax = 0;
    reset_n = 1;
  endtask

  task automatic test_reset();
    reset_dut(3);
    run_cycle(0, 11'h000, 0, 0, 11'h000, 8'h00);
    run_cycle(0, 11'h000, 0, 0, 11'h000, 8'h00);
  endtask

  task automatic test_video_only();
    for (int i = 0; i < 8; i++) begin
      run_cycle(1, 11'(i), 0, 0, 11'h000, 8'h00);
      run_cycle(0, 11'h000, 0, 0, 11'h000, 8'h00);
      nCmp++;
      if (obsVidValid !== 1'b1 || obsVidData !== 8'(i)) begin
        nFail++; $display("FAIL video_only[%0d]: got vv=%b vd=%h expected vv=1 vd=%h", i, obsVidValid, obsVidData, 8'(i));
      end
      run_cycle(0, 11'h000, 0, 0, 11'h000, 8'h00);
      nCmp++;
      if (obsVidValid !== 1'b0) begin
        nFail++; $display("FAIL video_only_strobe[%0d]: got vv=%b expected 0", i, obsVidValid);
      end
      for (int j = 0; j < 5; j++) run_cycle(0, 11'h000, 0, 0, 11'h000, 8'h00);
    end
  endtask

  task automatic test_cpu_write_read();
    run_cycle(0, 11'h000, 1, 1, 11'h7F0, 8'hA5);
    nCmp++;
    if (obsWe !== 1'b1 || obsAddr !== 11'h7F0) begin
      nFail++; $display("FAIL cpu_write_grant: got we=%b addr=%h expected we=1 addr=7f0", obsWe, obsAddr);
    end
    run_cycle(0, 11'h000, 1, 1, 11'h7F0, 8'hA5);
    nCmp++;
    if (obsAck !== 1'b1) begin
      nFail++; $display("FAIL cpu_write_ack: got %b expected 1", obsAck);
    end
    run_cycle(0, 11'h000, 1, 0, 11'h7F0, 8'h00);
    run_cycle(0, 11'h000, 1, 0, 11'h7F0, 8'h00);
    nCmp++;
    if (obsAck !== 1'b1 || obsRdata !== 8'hA5) begin
      nFail++; $display("FAIL cpu_read_back: got ack=%b rdata=%h expected ack=1 rdata=a5", obsAck, obsRdata);
    end
    run_cycle(0, 11'h000, 0, 0, 11'h000, 8'h00);
  endtask

  task automatic test_collision();
    run_cycle(1, 11'h020, 1, 0, 11'h010, 8'h00);
    nCmp++;
    if (obsAddr !== 11'h020 || obsWe !== 1'b0) begin
      nFail++; $display("FAIL collision_grant: got addr=%h we=%b expected addr=020 we=0", obsAddr, obsWe);
    end
    run_cycle(0, 11'h000, 1, 0, 11'h010, 8'h00);
    nCmp++;
    if (obsAddr !== 11'h010 || obsVidValid !== 1'b1 || obsVidData !== 8'h20 || obsAck !== 1'b0) begin
      nFail++; $display("FAIL collision_second: got addr=%h vv=%b vd=%h ack=%b expected 010/1/20/0",
                        obsAddr, obsVidValid, obsVidData, obsAck);
    end
    run_cycle(0, 11'h000, 1, 0, 11'h010, 8'h00);
    nCmp++;
    if (obsAck !== 1'b1 || obsRdata !== 8'h10) begin
      nFail++; $display("FAIL collision_ack: got ack=%b rdata=%h expected ack=1 rdata=10", obsAck, obsRdata);
    end
    run_cycle(0, 11'h000, 0, 0, 11'h000, 8'h00);
  endtask

  task automatic test_video_in_ack();
    run_cycle(0, 11'h000, 1, 0, 11'h123, 8'h00);
    run_cycle(1, 11'h7F0, 1, 0, 11'h123, 8'h00);
    nCmp++;
    if (obsAck !== 1'b1 || obsAddr !== 11'h7F0) begin
      nFail++; $display("FAIL ack_cycle_video: got ack=%b addr=%h expected ack=1 addr=7f0", obsAck, obsAddr);
    end
    run_cycle(0, 11'h000, 0, 0, 11'h000, 8'h00);
    nCmp++;
    if (obsVidValid !== 1'b1 || obsVidData !== 8'hA5 || obsAck !== 1'b0) begin
      nFail++; $display("FAIL ack_cycle_vid_valid: got vv=%b vd=%h ack=%b expected 1/a5/0", obsVidValid, obsVidData, obsAck);
    end
  endtask

  task automatic test_reset_mid_access();
    run_cycle(0, 11'h000, 1, 1, 11'h000, 8'h3C);
    reset_dut(1);
    nCmp++;
    if (obsAck !== 1'b0) begin
      nFail++; $display("FAIL reset_mid_grant_ack: got %b expected 0", obsAck);
    end
    run_cycle(0, 11'h000, 1, 0, 11'h000, 8'h00);
    run_cycle(0, 11'h000, 1, 0, 11'h000, 8'h00);
    nCmp++;
    if (obsAck !== 1'b1 || obsRdata !== 8'h3C) begin
      nFail++; $display("FAIL reset_then_read: got ack=%b rdata=%h expected ack=1 rdata=3c", obsAck, obsRdata);
    end
    run_cycle(0, 11'h000, 0, 0, 11'h000, 8'h00);
  endtask

  // Random mix of video strobes and well-behaved CPU transactions on a small
  // address window, so reads often hit recently written bytes.
  task automatic test_random_traffic();
    logic        pend, pwe, vr, inAck;
    logic [10:0] pa, va;
    logic [7:0]  pd;
    pend = 0; pwe = 0; pa = '0; pd = '0;
    for (int k = 0; k < 800; k++) begin
      if (!pend && $urandom_range(0, 2) == 0) begin
        pend = 1; pwe = 1'($urandom_range(0, 1));
        pa = 11'($urandom_range(0, 15)); pd = 8'($urandom);
      end
      vr = ($urandom_range(0, 3) == 0);
      va = 11'($urandom_range(0, 15));
      inAck = pend && (lastGrant == cyc - 1);
      run_cycle(vr, va, pend, pwe, pa, pd);
      if (inAck) pend = 0;
    end
    run_cycle(0, 11'h000, 0, 0, 11'h000, 8'h00);
  endtask

`ifdef VRAM_WAIT_STATS_EN
  task automatic test_wait_stats();
    reset_dut(2);
    for (int i = 0; i < 5; i++) run_cycle(1, 11'(i), 1, 0, 11'h005, 8'h00);
    run_cycle(0, 11'h000, 1, 0, 11'h005, 8'h00);
    nCmp++;
    if (obsWaitMax != 5) begin
      nFail++; $display("FAIL wait_max_5: got %0d expected 5", obsWaitMax);
    end
    run_cycle(0, 11'h000, 1, 0, 11'h005, 8'h00);
    for (int i = 0; i < 2; i++) run_cycle(1, 11'(i), 1, 0, 11'h006, 8'h00);
    run_cycle(0, 11'h000, 1, 0, 11'h006, 8'h00);
    run_cycle(0, 11'h000, 1, 0, 11'h006, 8'h00);
    run_cycle(0, 11'h000, 0, 0, 11'h000, 8'h00);
    nCmp++;
    if (obsWaitMax != 5) begin
      nFail++; $display("FAIL wait_max_hold: got %0d expected 5", obsWaitMax);
    end
    reset_dut(1);
    run_cycle(0, 11'h000, 0, 0, 11'h000, 8'h00);
    nCmp++;
    if (obsWaitMax != 0) begin
      nFail++; $display("FAIL wait_max_reset: got %0d expected 0", obsWaitMax);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 2048; i++) begin
      ram[i] = 8'(i);
      refMem[i] = 8'(i);
    end
    @(posedge clk); #1;
    test_reset();
    test_video_only();
    test_cpu_write_read();
    test_collision();
    test_video_in_ack();
    test_reset_mid_access();
    test_random_traffic();
`ifdef VRAM_WAIT_STATS_EN
    test_wait_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
